// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sequencer state encoding and index bit-reversal for the 8-point transform
package fft_pkg;
  localparam int FFT_N = 8;
  localparam int FFT_LOG2N = 3;
  localparam int FFT_W = 16;
  typedef enum logic [2:0] {S_LOAD, S_ISSUE, S_WAIT, S_WB, S_UNLOAD} state_e;
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] x);
    logic [FFT_LOG2N-1:0] r;
    for (int b = 0; b < FFT_LOG2N; b++) r[b] = x[FFT_LOG2N-1-b];
    return r;
  endfunction
endpackage

// File: rtl/fft8_sample_rf.sv
// fft8_sample_rf: 8 x W sample register file
// Ports: ld_en_i/ld_idx_i/ld_data_i single load write; wb_en_i writes c_i->rf[i_idx_i], d_i->rf[j_idx_i];
//        a_o/b_o async reads at i/j; u_o async read at u_idx_i. Contents survive reset.
module fft8_sample_rf import fft_pkg::*; #(
  parameter int W = FFT_W
) (
  input  logic                 clk,
  input  logic                 ld_en_i,
  input  logic [FFT_LOG2N-1:0] ld_idx_i,
  input  logic [W-1:0]         ld_data_i,
  input  logic                 wb_en_i,
  input  logic [FFT_LOG2N-1:0] i_idx_i,
  input  logic [FFT_LOG2N-1:0] j_idx_i,
  input  logic [W-1:0]         c_i,
  input  logic [W-1:0]         d_i,
  input  logic [FFT_LOG2N-1:0] u_idx_i,
  output logic [W-1:0]         a_o,
  output logic [W-1:0]         b_o,
  output logic [W-1:0]         u_o
);
  logic [W-1:0] rf_q [FFT_N];
  always_ff @(posedge clk) begin
    if (ld_en_i) rf_q[ld_idx_i] <= ld_data_i;
    if (wb_en_i) begin
      rf_q[i_idx_i] <= c_i;
      rf_q[j_idx_i] <= d_i;
    end
  end
  assign a_o = rf_q[i_idx_i];
  assign b_o = rf_q[j_idx_i];
  assign u_o = rf_q[u_idx_i];
endmodule

// File: rtl/fft8_seq_ctrl.sv
// fft8_seq_ctrl: sequences an external add/sub butterfly through an 8-point 3-stage in-place Walsh-Hadamard transform
// Ports: in_data/in_valid/in_ready sample input stream; out_data/out_valid/out_ready/out_last result stream;
//        busy high outside LOAD; bf_a/bf_b/bf_en/bf_ctrl drive the butterfly, bf_c/bf_d return its results.
// Build option: FFT8_BITREV_EN unloads results in bit-reversed index order instead of natural order.
module fft8_seq_ctrl import fft_pkg::*; #(
  parameter int BF_LAT = 1,
  parameter int W = FFT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic [W-1:0] bf_a,
  output logic [W-1:0] bf_b,
  output logic         bf_en,
  output logic         bf_ctrl,
  input  logic [W-1:0] bf_c,
  input  logic [W-1:0] bf_d
);
  localparam logic [FFT_LOG2N-1:0] LAST = FFT_LOG2N'(FFT_N - 1);
  state_e state_q, state_d;
  logic [FFT_LOG2N-1:0] cnt_q, cnt_d, k3, span, ii, jj, u_idx;
  logic [1:0] s_q, s_d, k_q, k_d, w_q, w_d;
  logic [W-1:0] rf_a, rf_b, rf_u;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q <= '0;
      s_q <= '0;
      k_q <= '0;
      w_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      s_q <= s_d;
      k_q <= k_d;
      w_q <= w_d;
    end
  end
  // Butterfly k of stage s pairs i and i+span, with span = 2^s
  always_comb begin
    k3 = {1'b0, k_q};
    span = FFT_LOG2N'(1) << s_q;
    ii = ((k3 >> s_q) << (s_q + 2'd1)) | (k3 & (span - FFT_LOG2N'(1)));
    jj = ii + span;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    s_d = s_q;
    k_d = k_q;
    w_d = '0;
    case (state_q)
      S_LOAD: begin
        cnt_d = in_valid ? cnt_q + 1'b1 : cnt_q;
        state_d = (in_valid && cnt_q == LAST) ? S_ISSUE : S_LOAD;
        s_d = '0;
        k_d = '0;
      end
      S_ISSUE: state_d = (BF_LAT > 1) ? S_WAIT : S_WB;
      // WAIT lasts BF_LAT-1 cycles so WB lands exactly when bf_c/bf_d become valid
      S_WAIT: begin
        w_d = w_q + 1'b1;
        state_d = (w_q == 2'(BF_LAT - 2)) ? S_WB : S_WAIT;
      end
      S_WB: begin
        k_d = k_q + 1'b1;
        s_d = (k_q == 2'd3) ? s_q + 1'b1 : s_q;
        cnt_d = '0;
        state_d = (s_q == 2'd2 && k_q == 2'd3) ? S_UNLOAD : S_ISSUE;
      end
      S_UNLOAD: begin
        cnt_d = out_ready ? cnt_q + 1'b1 : cnt_q;
        state_d = (out_ready && cnt_q == LAST) ? S_LOAD : S_UNLOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end
`ifdef FFT8_BITREV_EN
  assign u_idx = bitrev(cnt_q);
`else
  assign u_idx = cnt_q;
`endif
  always_comb begin
    in_ready = state_q == S_LOAD;
    busy = state_q != S_LOAD;
    bf_en = state_q == S_ISSUE;
    bf_a = bf_en ? rf_a : '0;
    bf_b = bf_en ? rf_b : '0;
    bf_ctrl = 1'b0;
    out_valid = state_q == S_UNLOAD;
    out_last = out_valid && cnt_q == LAST;
    out_data = out_valid ? rf_u : '0;
  end
  fft8_sample_rf #(.W(W)) u_rf (
    .clk(clk),
    .ld_en_i(in_ready && in_valid),
    .ld_idx_i(cnt_q),
    .ld_data_i(in_data),
    .wb_en_i(state_q == S_WB),
    .i_idx_i(ii),
    .j_idx_i(jj),
    .c_i(bf_c),
    .d_i(bf_d),
    .u_idx_i(u_idx),
    .a_o(rf_a),
    .b_o(rf_b),
    .u_o(rf_u)
  );
endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// tb_fft8_seq_ctrl: table-driven and randomized checks of the transform sequencer against a Walsh-Hadamard model
module tb_fft8_seq_ctrl;
  localparam int BF_LAT = 1;
  typedef struct {
    logic [15:0] x [8];
    logic [15:0] y [8];
  } vec_t;
  logic clk = 0, rst = 1;
  logic [15:0] in_data = 0, out_data, bf_a, bf_b, bf_c, bf_d;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, out_last, busy, bf_en, bf_ctrl;
  logic r3 = 1, v3 = 0, rdy3, ov3, ol3, busy3, en3, ctrl3, or3 = 0;
  logic [15:0] d3 = 0, od3, a3, b3, c3, dd3;
  logic [15:0] pc [4], pd [4], pc3 [4], pd3 [4];
  int checks = 0, failures = 0, acc = 0, ens = 0;
  vec_t tv [4];
  always #5 clk = ~clk;
  fft8_seq_ctrl #(.BF_LAT(BF_LAT), .W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .bf_a(bf_a), .bf_b(bf_b), .bf_en(bf_en), .bf_ctrl(bf_ctrl), .bf_c(bf_c), .bf_d(bf_d)
  );
  fft8_seq_ctrl #(.BF_LAT(3), .W(16)) dut3 (
    .clk(clk), .rst(r3), .in_data(d3), .in_valid(v3), .in_ready(rdy3),
    .out_data(od3), .out_valid(ov3), .out_ready(or3), .out_last(ol3),
    .busy(busy3), .bf_a(a3), .bf_b(b3), .bf_en(en3), .bf_ctrl(ctrl3), .bf_c(c3), .bf_d(dd3)
  );
  // External butterfly units with registered outputs, BF_LAT cycles deep
  always @(posedge clk) begin
    pc[0] <= bf_a + bf_b;
    pd[0] <= bf_a - bf_b;
    for (int q = 1; q < 4; q++) begin
      pc[q] <= pc[q-1];
      pd[q] <= pd[q-1];
    end
  end
  always @(posedge clk) begin
    pc3[0] <= a3 + b3;
    pd3[0] <= a3 - b3;
    for (int q = 1; q < 4; q++) begin
      pc3[q] <= pc3[q-1];
      pd3[q] <= pd3[q-1];
    end
  end
  assign bf_c = pc[BF_LAT-1];
  assign bf_d = pd[BF_LAT-1];
  assign c3 = pc3[2];
  assign dd3 = pd3[2];
  always @(posedge clk) begin
    if (in_valid && in_ready) acc <= acc + 1;
    if (bf_en) ens <= ens + 1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic int ord(input int c);
`ifdef FFT8_BITREV_EN
    return ((c & 1) << 2) | (c & 2) | (c >> 2);
`else
    return c;
`endif
  endfunction
  // Natural-order Hadamard transform: Y[m] = sum_n (-1)^popcount(m&n) x[n], modulo 2^16
  task automatic model(input logic [15:0] x [8], output logic [15:0] y [8]);
    for (int m = 0; m < 8; m++) begin
      y[m] = 0;
      for (int n = 0; n < 8; n++) y[m] = ($countones(m & n) % 2) ? y[m] - x[n] : y[m] + x[n];
    end
  endtask
  task automatic load(input logic [15:0] x [8], input bit bub);
    for (int n = 0; n < 8; n++) begin
      in_valid = 0;
      if (bub) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1;
      in_data = x[n];
      @(negedge clk);
    end
    in_valid = 0;
  endtask
  task automatic run_frame(input logic [15:0] x [8], input logic [15:0] y [8], input bit stall, input bit bub);
    int a0, e0, lat;
    a0 = acc;
    e0 = ens;
    load(x, bub);
    chk("first_issue_en", bf_en, 1);
    chk("first_issue_a", bf_a, x[0]);
    chk("first_issue_b", bf_b, x[1]);
    in_valid = bub;
    in_data = 16'hDEAD;
    lat = 0;
    while (!out_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 0;
    chk("latency", lat, 12 * (BF_LAT + 1));
    for (int c = 0; c < 8; c++) begin
      if (stall && c % 2 == 0) begin
        out_ready = 0;
        @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, y[ord(c)]);
      end
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, y[ord(c)]);
      chk("out_last", out_last, c == 7);
      out_ready = 1;
      @(negedge clk);
    end
    out_ready = 0;
    chk("back_in_ready", in_ready, 1);
    chk("back_busy", busy, 0);
    chk("back_out_valid", out_valid, 0);
    chk("accepts", acc - a0, 8);
    chk("issues", ens - e0, 12);
  endtask
  initial begin
    logic [15:0] x [8], y [8];
    int lat;
    for (int n = 0; n < 8; n++) begin
      tv[0].x[n] = (n == 0) ? 16'd1 : 16'd0;
      tv[0].y[n] = 16'd1;
      tv[1].x[n] = 16'd1;
      tv[1].y[n] = (n == 0) ? 16'd8 : 16'd0;
      tv[2].x[n] = (n == 1) ? 16'd1 : 16'd0;
      tv[2].y[n] = (n % 2) ? 16'hFFFF : 16'd1;
      tv[3].x[n] = 16'h7FFF;
      tv[3].y[n] = (n == 0) ? 16'hFFF8 : 16'd0;
    end
    repeat (3) @(negedge clk);
    rst = 0;
    r3 = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_bf_en", bf_en, 0);
    chk("rst_bf_a", bf_a, 0);
    chk("rst_bf_b", bf_b, 0);
    chk("rst_bf_ctrl", bf_ctrl, 0);
    for (int t = 0; t < 4; t++) run_frame(tv[t].x, tv[t].y, t == 2, t == 2);
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < 8; n++) x[n] = 16'($urandom);
      model(x, y);
      run_frame(x, y, r[0], r[1]);
    end
    load(tv[1].x, 0);
    repeat (4 * (BF_LAT + 1) + BF_LAT) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    run_frame(tv[0].x, tv[0].y, 0, 0);
    for (int n = 0; n < 8; n++) begin
      v3 = 1;
      d3 = (n == 0) ? 16'd1 : 16'd0;
      @(negedge clk);
    end
    v3 = 0;
    lat = 0;
    while (!ov3 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk("lat3_latency", lat, 48);
    for (int c = 0; c < 8; c++) begin
      chk("lat3_data", od3, 1);
      chk("lat3_last", ol3, c == 7);
      or3 = 1;
      @(negedge clk);
    end
    or3 = 0;
    chk("lat3_in_ready", rdy3, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
